// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback formatter: selects link/load/ALU data,
// extracts and extends load bytes/halves, and drives the register-file write port.
// Ports: clock/reset/stall/flush control, MEM-stage inputs (in_*), register-file
// outputs RegWrite/Write_reg/Write_data, plus wb_valid, align_err, retired_count.
module mem_wb_writeback #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_RegWrite,
  input  logic             in_MemtoReg,
  input  logic             in_link,
  input  logic [2:0]       in_load_type,
  input  logic [1:0]       in_byte_off,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_data,
  input  logic [31:0]      in_pc_plus8,
  input  logic [4:0]       in_write_reg,
  output logic             RegWrite,
  output logic [4:0]       Write_reg,
  output logic [31:0]      Write_data,
  output logic             wb_valid,
  output logic             align_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] sel_data;
  logic        is_half;
  logic        is_word;
  logic        misaligned;

  // Little-endian lane extraction; halfwords use only address bit 1.
  always_comb begin
    byte_lane = 8'h00;
    case (in_byte_off)
      2'd0:    byte_lane = in_mem_data[7:0];
      2'd1:    byte_lane = in_mem_data[15:8];
      2'd2:    byte_lane = in_mem_data[23:16];
      default: byte_lane = in_mem_data[31:24];
    endcase
    half_lane = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
  end

  always_comb begin
    load_data = in_mem_data;
    case (in_load_type)
      LT_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  load_data = {24'h000000, byte_lane};
      LT_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  load_data = {16'h0000, half_lane};
      default: load_data = in_mem_data; // LW and the unused codes 5-7
    endcase
  end

  always_comb begin
    is_half = (in_load_type == LT_LH) || (in_load_type == LT_LHU);
    is_word = !(is_half || (in_load_type == LT_LB) || (in_load_type == LT_LBU));
    // Link instructions and ALU ops never fault on the address bits.
    misaligned = in_MemtoReg && !in_link &&
                 ((is_half && in_byte_off[0]) || (is_word && (in_byte_off != 2'd0)));
    if (in_link)          sel_data = in_pc_plus8;
    else if (in_MemtoReg) sel_data = load_data;
    else                  sel_data = in_alu_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      RegWrite      <= 1'b0;
      Write_reg     <= 5'd0;
      Write_data    <= 32'd0;
      align_err     <= 1'b0;
      retired_count <= '0;
    end else if (stall) begin
      // Hold everything, flush included.
    end else if (flush) begin
      // Killed slot: address/data stay as-is, only the enables drop.
      wb_valid  <= 1'b0;
      RegWrite  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      wb_valid   <= in_valid;
      RegWrite   <= in_valid && in_RegWrite && (in_write_reg != 5'd0) && !misaligned;
      Write_reg  <= in_write_reg;
      Write_data <= sel_data;
      align_err  <= in_valid && misaligned;
      if (in_valid) retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vectors, a transaction-level model checked
// every cycle, and literal expectations on key results.
// Drives a default-width instance and a CNT_W=4 instance from the same inputs.
module tb_mem_wb_writeback;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_RegWrite, in_MemtoReg, in_link;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;
  logic [4:0]  in_write_reg;

  logic        RegWrite, wb_valid, align_err;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [31:0] retired_count;

  logic        RegWrite4, wb_valid4, align_err4;
  logic [4:0]  Write_reg4;
  logic [31:0] Write_data4;
  logic [3:0]  retired_count4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_wb_writeback dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_link(in_link), .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(RegWrite), .Write_reg(Write_reg), .Write_data(Write_data),
    .wb_valid(wb_valid), .align_err(align_err), .retired_count(retired_count)
  );

  mem_wb_writeback #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_link(in_link), .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(RegWrite4), .Write_reg(Write_reg4), .Write_data(Write_data4),
    .wb_valid(wb_valid4), .align_err(align_err4), .retired_count(retired_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          e_valid, e_rw, e_align, chk_en;
  logic [4:0]  e_wreg;
  logic [31:0] e_wdata;
  longint      e_cnt;

  // Access size in bytes and signedness from the load code.
  function automatic int ld_size(input logic [2:0] lt);
    if (lt == 3'd1 || lt == 3'd2) return 1;
    if (lt == 3'd3 || lt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_value(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] mem);
    int          sz;
    int          shift;
    logic [31:0] mask, v;
    sz = ld_size(lt);
    if (sz == 4) return mem;
    shift = (sz == 1) ? 8 * int'(off) : 16 * (int'(off) / 2);
    mask  = (sz == 1) ? 32'hFF : 32'hFFFF;
    v     = (mem >> shift) & mask;
    if ((lt == 3'd1 || lt == 3'd3) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clock) begin
    bit mis;
    if (reset) begin
      e_valid = 0; e_rw = 0; e_align = 0; e_wreg = 0; e_wdata = 0; e_cnt = 0;
      chk_en = 1;
    end else if (stall) begin
      // nothing changes
    end else if (flush) begin
      e_valid = 0; e_rw = 0; e_align = 0;
    end else begin
      mis = in_MemtoReg && !in_link &&
            ((ld_size(in_load_type) == 2 && (int'(in_byte_off) % 2) != 0) ||
             (ld_size(in_load_type) == 4 && in_byte_off != 0));
      e_valid = in_valid;
      e_wdata = in_link ? in_pc_plus8 :
                in_MemtoReg ? ld_value(in_load_type, in_byte_off, in_mem_data) : in_alu_result;
      e_wreg  = in_write_reg;
      e_rw    = in_valid && in_RegWrite && in_write_reg != 0 && !mis;
      e_align = in_valid && mis;
      if (in_valid) e_cnt = e_cnt + 1;
    end
    #1;
    if (chk_en) begin
      chk("wb_valid",   {31'd0, wb_valid},  {31'd0, e_valid});
      chk("RegWrite",   {31'd0, RegWrite},  {31'd0, e_rw});
      chk("align_err",  {31'd0, align_err}, {31'd0, e_align});
      chk("Write_reg",  {27'd0, Write_reg}, {27'd0, e_wreg});
      chk("Write_data", Write_data, e_wdata);
      chk("count32",    retired_count, 32'(e_cnt % 64'h1_0000_0000));
      chk("count4",     {28'd0, retired_count4}, 32'(e_cnt % 16));
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic v, input logic rw, input logic m2r, input logic lnk,
                    input logic [2:0] lt, input logic [1:0] off,
                    input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc8,
                    input logic [4:0] wr, input logic st, input logic fl);
    @(negedge clock);
    in_valid = v; in_RegWrite = rw; in_MemtoReg = m2r; in_link = lnk;
    in_load_type = lt; in_byte_off = off; in_alu_result = alu; in_mem_data = mem;
    in_pc_plus8 = pc8; in_write_reg = wr; stall = st; flush = fl;
    @(posedge clock);
    #2;
  endtask

  initial begin
    chk_en = 0;
    reset = 1; stall = 0; flush = 0;

    // 1: reset with a valid instruction presented
    op(1, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd8, 0, 0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wdata", Write_data, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    reset = 0;

    // 2: ALU op
    op(1, 1, 0, 0, 0, 0, 32'h12345678, 32'h0, 32'h0, 5'd8, 0, 0);
    chk("alu_rw",    {31'd0, RegWrite}, 32'd1);
    chk("alu_wreg",  {27'd0, Write_reg}, 32'd8);
    chk("alu_wdata", Write_data, 32'h12345678);
    chk("alu_count", retired_count, 32'd1);

    // 3: byte/half extraction
    op(1, 1, 1, 0, 3'd1, 2'd2, 32'h0, 32'h00800000, 32'h0, 5'd9, 0, 0);
    chk("lb_wdata", Write_data, 32'hFFFFFF80);
    op(1, 1, 1, 0, 3'd2, 2'd2, 32'h0, 32'h00800000, 32'h0, 5'd9, 0, 0);
    chk("lbu_wdata", Write_data, 32'h00000080);
    op(1, 1, 1, 0, 3'd4, 2'd2, 32'h0, 32'hBEEF0000, 32'h0, 5'd9, 0, 0);
    chk("lhu_wdata", Write_data, 32'h0000BEEF);
    op(1, 1, 1, 0, 3'd3, 2'd0, 32'h0, 32'h12348001, 32'h0, 5'd9, 0, 0);
    chk("lh_wdata", Write_data, 32'hFFFF8001);
    op(1, 1, 1, 0, 3'd7, 2'd0, 32'h0, 32'hCAFEF00D, 32'h0, 5'd9, 0, 0);
    chk("lw7_wdata", Write_data, 32'hCAFEF00D);
    chk("lw7_count", retired_count, 32'd6);

    // 4: misaligned LH, then ALU write to $0
    op(1, 1, 1, 0, 3'd3, 2'd1, 32'h0, 32'h11223344, 32'h0, 5'd10, 0, 0);
    chk("mis_align", {31'd0, align_err}, 32'd1);
    chk("mis_rw",    {31'd0, RegWrite}, 32'd0);
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_count", retired_count, 32'd7);
    op(1, 1, 0, 0, 0, 0, 32'h55555555, 32'h0, 32'h0, 5'd0, 0, 0);
    chk("r0_rw", {31'd0, RegWrite}, 32'd0);
    op(1, 1, 1, 0, 3'd0, 2'd2, 32'h0, 32'h0, 32'h0, 5'd3, 0, 0);
    chk("lw_mis", {31'd0, align_err}, 32'd1);
    op(1, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd4, 0, 0);

    // 5: stall+flush holds; flush alone kills enables only
    op(1, 1, 0, 0, 0, 0, 32'h0BADF00D, 32'h0, 32'h0, 5'd6, 1, 1);
    chk("stl_wdata", Write_data, 32'hA5A5A5A5);
    chk("stl_rw",    {31'd0, RegWrite}, 32'd1);
    chk("stl_count", retired_count, 32'd10);
    op(1, 1, 0, 0, 0, 0, 32'h0BADF00D, 32'h0, 32'h0, 5'd6, 0, 1);
    chk("fl_valid", {31'd0, wb_valid}, 32'd0);
    chk("fl_rw",    {31'd0, RegWrite}, 32'd0);
    chk("fl_wdata", Write_data, 32'hA5A5A5A5);
    chk("fl_wreg",  {27'd0, Write_reg}, 32'd4);

    // 6: JAL with MemtoReg set and a misaligned-looking offset
    op(1, 1, 1, 1, 3'd3, 2'd1, 32'h0, 32'hFFFFFFFF, 32'h00400010, 5'd31, 0, 0);
    chk("jal_wdata", Write_data, 32'h00400010);
    chk("jal_rw",    {31'd0, RegWrite}, 32'd1);
    chk("jal_align", {31'd0, align_err}, 32'd0);
    chk("jal_count", retired_count, 32'd11);

    // Bubble (in_valid=0) must not count
    op(0, 1, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 5'd2, 0, 0);
    chk("bub_count", retired_count, 32'd11);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 4; i++)
      op(1, 1, 0, 0, 0, 0, 32'(i), 32'h0, 32'h0, 5'd5, 0, 0);
    chk("c4_15", {28'd0, retired_count4}, 32'd15);
    op(1, 0, 0, 0, 0, 0, 32'h7, 32'h0, 32'h0, 5'd5, 0, 0);
    chk("c4_wrap", {28'd0, retired_count4}, 32'd0);
    chk("c32_16",  retired_count, 32'd16);

    // Reset while stalled and flushed wins
    reset = 1;
    op(1, 1, 0, 0, 0, 0, 32'h9, 32'h0, 32'h0, 5'd5, 1, 1);
    chk("rst_stl_count", retired_count, 32'd0);
    chk("rst_stl_wreg",  {27'd0, Write_reg}, 32'd0);
    reset = 0;
    op(1, 1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd12, 0, 0);
    chk("post_rst_wdata", Write_data, 32'h77);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
